// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg: shared ctrl bit indices, mov/branch encodings and FSM state
package ex_mem_stage_pkg;
    localparam int CTRL_W       = 6;
    localparam int CTRL_REGW    = 5;
    localparam int CTRL_MRD     = 4;
    localparam int CTRL_MWR     = 3;
    localparam int CTRL_SIZE_HI = 2;
    localparam int CTRL_SIZE_LO = 1;
    localparam int CTRL_SGN     = 0;

    localparam logic [1:0] MOV_NONE = 2'b00;
    localparam logic [1:0] MOVZ     = 2'b01;
    localparam logic [1:0] MOVN     = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_T    = 2'b01;
    localparam logic [1:0] BR_F    = 2'b10;

    typedef enum logic {ST_RUN = 1'b0, ST_SLOT = 1'b1} state_t;

    function automatic logic is_branch(input logic [1:0] br);
        return (br == BR_T) || (br == BR_F);
    endfunction
endpackage

// File: rtl/ex_mem_stage_branch_resolve.sv
// branch_resolve: decides whether the instruction in EX is a taken branch
module branch_resolve
    import ex_mem_stage_pkg::*;
(
    input  logic       ex_valid,
    input  logic [1:0] ex_branch,
    input  logic       result_lsb,
    input  state_t     state,
    output logic       taken
);
    // A branch sitting in a delay slot is never taken.
    assign taken = ex_valid & (state == ST_RUN) &
                   (ex_branch == BR_T ? result_lsb : ex_branch == BR_F ? !result_lsb : 1'b0);
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with MOVN/MOVZ qualification,
// branch redirect, delay-slot tracking and forwarding bus.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_result,
    input  logic               ex_zero,
    input  logic [DATA_W-1:0]  ex_store_data,
    input  logic               ex_b_is_zero,
    input  logic [RADDR_W-1:0] ex_dest,
    input  logic [CTRL_W-1:0]  ex_ctrl,
    input  logic [1:0]         ex_mov,
    input  logic [1:0]         ex_branch,
    input  logic [DATA_W-1:0]  ex_br_target,
    input  logic               stall,
    input  logic               flush,
    output logic               mem_valid,
    output logic [DATA_W-1:0]  mem_result,
    output logic [DATA_W-1:0]  mem_store_data,
    output logic [RADDR_W-1:0] mem_dest,
    output logic [CTRL_W-1:0]  mem_ctrl,
    output logic               redirect,
    output logic [DATA_W-1:0]  redirect_pc,
    output logic               slot_branch_err,
    output logic               fwd_en,
    output logic [RADDR_W-1:0] fwd_dest,
    output logic [DATA_W-1:0]  fwd_data
);
    state_t state, state_nx;
    logic   taken, regw, slot_br, capture;

    branch_resolve u_branch_resolve (
        .ex_valid   (ex_valid),
        .ex_branch  (ex_branch),
        .result_lsb (ex_result[0]),
        .state      (state),
        .taken      (taken)
    );

    assign capture = !stall & !flush;

    always_comb begin
        regw     = ex_ctrl[CTRL_REGW] & ex_valid &
                   (ex_mov == MOVZ ? ex_b_is_zero : ex_mov == MOVN ? !ex_b_is_zero : 1'b1);
        slot_br  = ex_valid & (state == ST_SLOT) & is_branch(ex_branch);
        state_nx = stall ? state : flush ? ST_RUN :
                   state == ST_RUN ? (taken ? ST_SLOT : ST_RUN) :
                   (ex_valid ? ST_RUN : ST_SLOT);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nx;
    end

    // ex_zero is carried by the ALU interface but plays no part in branch resolution.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid       <= 1'b0;
            mem_result      <= '0;
            mem_store_data  <= '0;
            mem_dest        <= '0;
            mem_ctrl        <= '0;
            redirect        <= 1'b0;
            redirect_pc     <= '0;
            slot_branch_err <= 1'b0;
        end else if (stall) begin
            redirect <= 1'b0;
        end else begin
            mem_valid       <= ex_valid & !flush;
            mem_result      <= ex_result;
            mem_store_data  <= ex_store_data;
            mem_dest        <= ex_dest;
            mem_ctrl        <= (flush | !ex_valid) ? '0 : {regw, ex_ctrl[CTRL_REGW-1:0]};
            redirect        <= taken & !flush;
            redirect_pc     <= (taken & !flush) ? ex_br_target : redirect_pc;
            slot_branch_err <= slot_branch_err | (slot_br & capture);
        end
    end

    assign fwd_en   = mem_valid & mem_ctrl[CTRL_REGW] & (mem_dest != '0);
    assign fwd_dest = mem_dest;
    assign fwd_data = mem_result;

    logic unused_ok;
    assign unused_ok = ex_zero;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed scenarios plus random traffic against a transaction-level model
module tb_ex_mem_stage;
    logic        clk = 1'b0;
    logic        reset, ex_valid, ex_zero, ex_b_is_zero, stall, flush;
    logic [31:0] ex_result, ex_store_data, ex_br_target;
    logic [4:0]  ex_dest;
    logic [5:0]  ex_ctrl;
    logic [1:0]  ex_mov, ex_branch;
    logic        mem_valid, redirect, slot_branch_err, fwd_en;
    logic [31:0] mem_result, mem_store_data, redirect_pc, fwd_data;
    logic [4:0]  mem_dest, fwd_dest;
    logic [5:0]  mem_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    // model of the architecturally visible state
    bit          m_valid, m_redirect, m_err, m_in_slot;
    bit [31:0]   m_result, m_sd, m_rpc;
    bit [4:0]    m_dest;
    bit [5:0]    m_ctrl;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result), .ex_zero(ex_zero),
        .ex_store_data(ex_store_data), .ex_b_is_zero(ex_b_is_zero), .ex_dest(ex_dest),
        .ex_ctrl(ex_ctrl), .ex_mov(ex_mov), .ex_branch(ex_branch), .ex_br_target(ex_br_target),
        .stall(stall), .flush(flush), .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .mem_dest(mem_dest), .mem_ctrl(mem_ctrl),
        .redirect(redirect), .redirect_pc(redirect_pc), .slot_branch_err(slot_branch_err),
        .fwd_en(fwd_en), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit is_br, tk, wr;
        if (reset) begin
            {m_valid, m_redirect, m_err, m_in_slot} = '0;
            {m_result, m_sd, m_rpc, m_dest, m_ctrl} = '0;
        end else if (stall) begin
            m_redirect = 0;
        end else begin
            is_br = (ex_branch == 2'd1) || (ex_branch == 2'd2);
            tk = ex_valid && !m_in_slot &&
                 ((ex_branch == 2'd1 && ex_result[0]) || (ex_branch == 2'd2 && !ex_result[0]));
            case (ex_mov)
                2'd1:    wr = ex_b_is_zero;
                2'd2:    wr = !ex_b_is_zero;
                default: wr = 1;
            endcase
            m_result = ex_result;
            m_sd     = ex_store_data;
            m_dest   = ex_dest;
            if (flush) begin
                m_valid = 0; m_ctrl = 0; m_redirect = 0; m_in_slot = 0;
            end else begin
                m_valid    = ex_valid;
                m_ctrl     = ex_valid ? {ex_ctrl[5] & wr, ex_ctrl[4:0]} : 6'd0;
                m_redirect = tk;
                if (tk) m_rpc = ex_br_target;
                if (ex_valid && m_in_slot && is_br) m_err = 1;
                m_in_slot  = m_in_slot ? !ex_valid : tk;
            end
        end
    endtask

    task automatic compare_all();
        check("mem_valid", 64'(mem_valid), 64'(m_valid));
        check("mem_result", 64'(mem_result), 64'(m_result));
        check("mem_store_data", 64'(mem_store_data), 64'(m_sd));
        check("mem_dest", 64'(mem_dest), 64'(m_dest));
        check("mem_ctrl", 64'(mem_ctrl), 64'(m_ctrl));
        check("redirect", 64'(redirect), 64'(m_redirect));
        if (m_redirect) check("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
        check("slot_branch_err", 64'(slot_branch_err), 64'(m_err));
        check("fwd_en", 64'(fwd_en), 64'(m_valid && m_ctrl[5] && m_dest != 0));
        check("fwd_dest", 64'(fwd_dest), 64'(m_dest));
        check("fwd_data", 64'(fwd_data), 64'(m_result));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_ex(input logic v, input logic [31:0] res, input logic bz, input logic [4:0] dest,
                          input logic [5:0] ctrl, input logic [1:0] mov, input logic [1:0] br,
                          input logic [31:0] tgt);
        ex_valid = v; ex_result = res; ex_b_is_zero = bz; ex_dest = dest; ex_ctrl = ctrl;
        ex_mov = mov; ex_branch = br; ex_br_target = tgt;
        ex_zero = 1'($urandom); ex_store_data = $urandom;
        stall = 0; flush = 0; reset = 0;
    endtask

    task automatic add_op(input logic [31:0] res, input logic [4:0] dest);
        set_ex(1, res, 0, dest, 6'b100000, 2'd0, 2'd0, 32'h0);
    endtask

    task automatic branch_op(input logic [1:0] br, input logic [31:0] res, input logic [31:0] tgt);
        set_ex(1, res, 0, 5'd0, 6'b000000, 2'd0, br, tgt);
    endtask

    initial begin
        logic [31:0] held;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        tick();
        tick();
        check("rst_redirect", 64'(redirect), 64'd0);

        // 1: plain ADD
        add_op(32'h5, 5'd8);
        tick();
        check("t1_result", 64'(mem_result), 64'h5);
        check("t1_fwd_en", 64'(fwd_en), 64'd1);
        check("t1_fwd_dest", 64'(fwd_dest), 64'd8);

        // 2: MOVZ both ways
        set_ex(1, 32'h77, 0, 5'd9, 6'b100000, 2'd1, 2'd0, 0);
        tick();
        check("t2_movz_nw", 64'(mem_ctrl[5]), 64'd0);
        check("t2_fwd_off", 64'(fwd_en), 64'd0);
        set_ex(1, 32'h77, 1, 5'd9, 6'b100000, 2'd1, 2'd0, 0);
        tick();
        check("t2_movz_w", 64'(mem_ctrl[5]), 64'd1);

        // 3: taken BEQ, slot passes through, back in RUN
        branch_op(2'd1, 32'h1, 32'h0040_0020);
        tick();
        check("t3_redirect", 64'(redirect), 64'd1);
        check("t3_pc", 64'(redirect_pc), 64'h0040_0020);
        add_op(32'h11, 5'd4);
        tick();
        check("t3_pulse_end", 64'(redirect), 64'd0);
        check("t3_slot_kept", 64'(mem_valid), 64'd1);
        branch_op(2'd2, 32'h2, 32'h0040_0100);
        tick();
        check("t3_run_again", 64'(redirect), 64'd1);
        add_op(32'h12, 5'd5);
        tick();

        // 5: stall on the capture of a taken branch
        held = mem_result;
        branch_op(2'd1, 32'h3, 32'h0040_0200);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_stall_redir", 64'(redirect), 64'd0);
            check("t5_stall_hold", 64'(mem_result), 64'(held));
        end
        stall = 0;
        tick();
        check("t5_redirect", 64'(redirect), 64'd1);
        check("t5_pc", 64'(redirect_pc), 64'h0040_0200);
        add_op(32'h13, 5'd6);
        tick();
        check("t5_single", 64'(redirect), 64'd0);

        // 6: flush a valid ADD, then flush while in SLOT
        add_op(32'h99, 5'd3);
        flush = 1;
        tick();
        check("t6_valid", 64'(mem_valid), 64'd0);
        check("t6_ctrl", 64'(mem_ctrl), 64'd0);
        check("t6_fwd", 64'(fwd_en), 64'd0);
        branch_op(2'd1, 32'h1, 32'h0040_0300);
        tick();
        add_op(32'h1, 5'd7);
        flush = 1;
        tick();
        branch_op(2'd1, 32'h1, 32'h0040_0400);
        tick();
        check("t6_run_redir", 64'(redirect), 64'd1);
        check("t6_no_err", 64'(slot_branch_err), 64'd0);
        add_op(32'h2, 5'd7);
        tick();

        // 4: branch in delay slot
        branch_op(2'd1, 32'h1, 32'h0040_0500);
        tick();
        branch_op(2'd1, 32'h1, 32'h0040_0600);
        tick();
        check("t4_no_redir", 64'(redirect), 64'd0);
        check("t4_err", 64'(slot_branch_err), 64'd1);
        for (int i = 0; i < 3; i++) begin
            add_op($urandom, 5'(i + 1));
            tick();
            check("t4_sticky", 64'(slot_branch_err), 64'd1);
        end
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        tick();
        check("t4_rst_clr", 64'(slot_branch_err), 64'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            set_ex(1'($urandom_range(0, 9) != 0), $urandom, 1'($urandom), 5'($urandom),
                   6'($urandom), 2'($urandom), 2'($urandom), $urandom & 32'hffff_fffc);
            stall = ($urandom_range(0, 6) == 0);
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
